bcd_countdown: RTL and testbench

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

---
 rtl/bcd_countdown.sv | 184 ++++++++++++++++++
 tb/tb_bcd_countdown.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown.sv
// Millisecond countdown timer: converts an hh:mm:ss.mmm BCD preset into a binary
// millisecond count, then decrements it once per tick while enabled.
module bcd_countdown #(
  parameter int BITS = 29
) (
  input  logic            NEclk,
  input  logic            reset,
  input  logic            tick,
  input  logic            load,
  input  logic            Enable,
  input  logic [3:0]      bcd_h_1,
  input  logic [3:0]      bcd_h_0,
  input  logic [3:0]      bcd_min_1,
  input  logic [3:0]      bcd_min_0,
  input  logic [3:0]      bcd_s_1,
  input  logic [3:0]      bcd_s_0,
  input  logic [3:0]      bcd_ms_2,
  input  logic [3:0]      bcd_ms_1,
  input  logic [3:0]      bcd_ms_0,
  output logic [BITS-1:0] count,
  output logic            busy,
  output logic            ready,
  output logic            expired,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [8:0][3:0]   snap_q, snap_d;
  logic [BITS-1:0]   acc_q, acc_d;
  logic [3:0]        idx_q, idx_d;
  logic [BITS-1:0]   count_q, count_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              expired_q, expired_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [3:0]        digit_s;
  logic [BITS-1:0]   acc_next_s;

  // Weight of each digit position: hours x1, tens x10/x6 alternate, ms digits x10.
  function automatic logic [BITS-1:0] acc_step(input logic [BITS-1:0] acc,
                                               input logic [3:0] idx,
                                               input logic [3:0] dig);
    logic [BITS-1:0] scaled;
    case (idx)
      4'd0:       scaled = acc;
      4'd2, 4'd4: scaled = (acc << 2) + (acc << 1);
      default:    scaled = (acc << 3) + (acc << 1);
    endcase
    return scaled + BITS'(dig);
  endfunction

  // Tens-of-minutes and tens-of-seconds positions only go up to 5.
  function automatic logic digit_bad(input logic [3:0] idx, input logic [3:0] dig);
    return (dig > 4'd9) || (((idx == 4'd2) || (idx == 4'd4)) && (dig > 4'd5));
  endfunction

  assign digit_s    = (idx_q <= 4'd8) ? snap_q[idx_q] : 4'd0;
  assign acc_next_s = acc_step(acc_q, idx_q, digit_s);

  // Next-state, datapath and registered-flag computation.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      snap_d[0] = bcd_h_1;
      snap_d[1] = bcd_h_0;
      snap_d[2] = bcd_min_1;
      snap_d[3] = bcd_min_0;
      snap_d[4] = bcd_s_1;
      snap_d[5] = bcd_s_0;
      snap_d[6] = bcd_ms_2;
      snap_d[7] = bcd_ms_1;
      snap_d[8] = bcd_ms_0;
      acc_d     = '0;
      idx_d     = 4'd0;
      count_d   = '0;
      state_d   = CONV;
    end else begin
      case (state_q)
        IDLE: count_d = '0;
        CONV: begin
          count_d = '0;
          if (digit_bad(idx_q, digit_s)) begin
            state_d = ERR;
          end else if (idx_q == 4'd8) begin
            acc_d   = acc_next_s;
            count_d = acc_next_s;
            idx_d   = 4'd0;
            state_d = READY;
          end else begin
            acc_d = acc_next_s;
            idx_d = idx_q + 4'd1;
          end
        end
        READY: begin
          if (Enable) begin
            if (count_q == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = READY;
          end
        end
        RUN: begin
          // The <=1 guard keeps the count from ever wrapping below zero.
          if (tick && Enable) begin
            if (count_q <= BITS'(1)) begin
              count_d = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              count_d = count_q - BITS'(1);
            end
          end else begin
            count_d = count_q;
          end
        end
        DONE:    count_d = '0;
        ERR:     count_d = '0;
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
    busy_d    = (state_d == CONV) || (state_d == RUN);
    ready_d   = (state_d == READY);
    expired_d = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  // State and output registers, falling-edge clocked with async clear.
  always_ff @(negedge NEclk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      acc_q     <= '0;
      idx_q     <= 4'd0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      expired_q <= expired_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign ready   = ready_q;
  assign expired = expired_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown: a preset conversion table plus hand-written
// sequences for countdown, pause, abort, error and reset behaviour.
module tb_bcd_countdown;

  logic        clk = 1'b1;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic [35:0] preset = 36'h0;
  logic [28:0] count;
  logic        busy, ready, expired, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_countdown #(.BITS(29)) dut (
    .NEclk(clk), .reset(reset), .tick(tick), .load(load), .Enable(en),
    .bcd_h_1(preset[35:32]), .bcd_h_0(preset[31:28]),
    .bcd_min_1(preset[27:24]), .bcd_min_0(preset[23:20]),
    .bcd_s_1(preset[19:16]), .bcd_s_0(preset[15:12]),
    .bcd_ms_2(preset[11:8]), .bcd_ms_1(preset[7:4]), .bcd_ms_0(preset[3:0]),
    .count(count), .busy(busy), .ready(ready), .expired(expired),
    .done(done), .err(err)
  );

  typedef struct {
    logic [35:0] digits;
    logic        exp_err;
    int          exp_count;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load_preset(input logic [35:0] p);
    preset = p;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_expired"}, expired, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{36'h000001500, 1'b0, 1500};
    vecs[1]  = '{36'h995959999, 1'b0, 359999999};
    vecs[2]  = '{36'h123456789, 1'b0, 45296789};
    vecs[3]  = '{36'h000000005, 1'b0, 5};
    vecs[4]  = '{36'h000000000, 1'b0, 0};
    vecs[5]  = '{36'h010000000, 1'b0, 3600000};
    vecs[6]  = '{36'h001000000, 1'b0, 600000};
    vecs[7]  = '{36'h005900000, 1'b0, 3540000};
    vecs[8]  = '{36'h000060000, 1'b1, 0};
    vecs[9]  = '{36'h006000000, 1'b1, 0};
    vecs[10] = '{36'h0A0000000, 1'b1, 0};
    vecs[11] = '{36'h00000000F, 1'b1, 0};

    // Reset held: everything reads zero, and idle persists after release.
    #13;
    chk_all_zero("rst");
    reset = 1'b1;
    en = 1'b1;
    tick = 1'b1;
    step();
    step();
    chk_all_zero("idle");
    en = 1'b0;
    tick = 1'b0;

    // Conversion table.
    foreach (vecs[k]) begin
      load_preset(vecs[k].digits);
      repeat (9) step();
      chk($sformatf("tbl%0d_count", k), count, vecs[k].exp_count);
      chk($sformatf("tbl%0d_err", k), err, vecs[k].exp_err);
      chk($sformatf("tbl%0d_ready", k), ready, !vecs[k].exp_err);
      chk($sformatf("tbl%0d_busy", k), busy, 0);
    end

    // 1.500 s full countdown.
    load_preset(36'h000001500);
    repeat (8) step();
    chk("cd_conv_busy", busy, 1);
    chk("cd_conv_count", count, 0);
    step();
    chk("cd_ready", ready, 1);
    chk("cd_loaded", count, 1500);
    en = 1'b1;
    step();
    chk("cd_run_busy", busy, 1);
    chk("cd_run_count", count, 1500);
    for (int i = 1; i <= 1500; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (i == 1499) begin
        chk("cd_at1_count", count, 1);
        chk("cd_at1_done", done, 0);
      end
      if (i == 1500) begin
        chk("cd_end_count", count, 0);
        chk("cd_end_done", done, 1);
        chk("cd_end_expired", expired, 1);
        chk("cd_end_busy", busy, 0);
      end
      step();
    end
    chk("cd_done_once", done, 0);
    pulse_ticks(3);
    chk("cd_hold_count", count, 0);
    chk("cd_hold_expired", expired, 1);
    chk("cd_hold_done", done, 0);
    en = 1'b0;

    // Pause and resume.
    load_preset(36'h000001000);
    repeat (9) step();
    en = 1'b1;
    step();
    en = 1'b0;
    pulse_ticks(200);
    chk("pause_count", count, 1000);
    chk("pause_busy", busy, 1);
    en = 1'b1;
    pulse_ticks(10);
    chk("resume_count", count, 990);

    // Load during RUN aborts and reconverts.
    load_preset(36'h000000005);
    chk("abort_busy", busy, 1);
    chk("abort_count", count, 0);
    repeat (8) step();
    chk("abort_conv_busy", busy, 1);
    step();
    chk("abort_count5", count, 5);
    chk("abort_ready", ready, 1);
    step();
    chk("abort_run", busy, 1);

    // Asynchronous reset mid-RUN, checked before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk_all_zero("arst");
    #1 reset = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk_all_zero("arst_idle");
    en = 1'b0;

    // Bad tens-of-minutes digit errors exactly at the third edge.
    load_preset(36'h006000000);
    step();
    step();
    chk("err_e2", err, 0);
    step();
    chk("err_e3", err, 1);
    chk("err_e3_count", count, 0);
    chk("err_e3_busy", busy, 0);
    repeat (4) step();
    chk("err_stuck", err, 1);
    load_preset(36'h000000005);
    repeat (9) step();
    chk("err_rec_count", count, 5);
    chk("err_rec_ready", ready, 1);
    chk("err_rec_err", err, 0);

    // Zero preset goes straight to DONE.
    load_preset(36'h000000000);
    repeat (9) step();
    chk("zero_ready", ready, 1);
    en = 1'b1;
    step();
    chk("zero_done", done, 1);
    chk("zero_expired", expired, 1);
    chk("zero_count", count, 0);
    step();
    chk("zero_done_once", done, 0);
    chk("zero_expired2", expired, 1);
    en = 1'b0;

    // Load mid-CONV restarts from the new snapshot.
    load_preset(36'h000001500);
    repeat (4) step();
    load_preset(36'h000000007);
    repeat (9) step();
    chk("reconv_count", count, 7);
    chk("reconv_ready", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
